// File: rtl/shreg_capture_ctrl.sv
// ---------------------------------------------------------------------------
// shreg_capture_ctrl
// Capture sequencer for the multi-lane sample shift register (shreg).
// Keeps shreg shifting, arms on request, waits until a full pre-trigger
// window has been shifted in, then detects a trigger. The trigger is either
// an external pulse or a signed level threshold crossed on any incoming
// lane. After a programmable post-trigger interval it freezes shreg and
// streams the frozen window out, oldest word first, over valid/ready.
//
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   arm             one-cycle start request (only honoured in IDLE)
//   abort           return to IDLE from any state, highest priority
//   ext_trig        external trigger pulse
//   thr_en          enables the level trigger
//   threshold       signed trigger level (any lane >= threshold)
//   post_cycles     clocks to keep shifting after the trigger cycle
//   din             lane samples entering shreg (lane i at bits i*DWIDTH)
//   dout            shreg contents, word 0 newest, word BUFLEN-1 oldest
//   shift_en        shift enable to shreg
//   out_data        readout word (mux of dout by read count)
//   out_valid       out_data valid
//   out_ready       downstream accepts word
//   out_last        final word of the window
//   busy            sequencer not idle
//   trig_lane       lowest lane that met the threshold (0 for ext_trig)
//   done            one-cycle pulse after the final accepted word
// ---------------------------------------------------------------------------
module shreg_capture_ctrl #(
  parameter int DWIDTH = 14,
  parameter int UNR    = 4,
  parameter int BUFLEN = 40,
  parameter int PWIDTH = 8,
  localparam int TLW   = (UNR > 1) ? $clog2(UNR) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       ext_trig,
  input  logic                       thr_en,
  input  logic signed [DWIDTH-1:0]   threshold,
  input  logic [PWIDTH-1:0]          post_cycles,
  input  logic [UNR*DWIDTH-1:0]      din,
  input  logic [BUFLEN*DWIDTH-1:0]   dout,
  output logic                       shift_en,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [TLW-1:0]             trig_lane,
  output logic                       done
);

  localparam int FILL_MAX = BUFLEN / UNR;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);
  localparam int RD_W     = (BUFLEN > 1) ? $clog2(BUFLEN) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, POST, READ} state_t;

  state_t              state_r;
  logic [FILL_W-1:0]   fill_r;
  logic [PWIDTH-1:0]   post_r;
  logic [RD_W-1:0]     rd_cnt_r;
  logic                shift_en_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic                done_r;
  logic [TLW-1:0]      trig_lane_r;

  logic [UNR-1:0]      lane_ge_s;
  logic [TLW-1:0]      hit_lane_s;
  logic                trig_s;
  int                  rd_idx_s;
  logic [DWIDTH-1:0]   rd_word_s;

  // Level compare per lane; scanning downward leaves the lowest hit lane.
  always_comb begin
    lane_ge_s  = '0;
    hit_lane_s = '0;
    for (int i = UNR - 1; i >= 0; i--) begin
      lane_ge_s[i] = $signed(din[i*DWIDTH +: DWIDTH]) >= threshold;
      hit_lane_s   = lane_ge_s[i] ? TLW'(i) : hit_lane_s;
    end
    trig_s = ext_trig | (thr_en & (|lane_ge_s));
  end

  // Readout mux: oldest word first, forced to zero when nothing is offered.
  always_comb begin
    rd_idx_s  = BUFLEN - 1 - int'(rd_cnt_r);
    rd_word_s = dout[rd_idx_s*DWIDTH +: DWIDTH];
    if (out_valid_r) begin
      out_data = rd_word_s;
    end else begin
      out_data = '0;
    end
  end

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      fill_r      <= '0;
      post_r      <= '0;
      rd_cnt_r    <= '0;
      shift_en_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
      trig_lane_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state_r     <= IDLE;
        fill_r      <= '0;
        post_r      <= '0;
        rd_cnt_r    <= '0;
        shift_en_r  <= 1'b1;
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        trig_lane_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            fill_r <= '0;
            if (arm) begin
              // The arm edge already counts as the first fill beat.
              state_r <= ARMED;
              fill_r  <= FILL_W'(1);
            end
          end
          ARMED: begin
            if (fill_r == FILL_W'(FILL_MAX)) begin
              if (trig_s) begin
                trig_lane_r <= ext_trig ? TLW'(0) : hit_lane_s;
                if (post_cycles == PWIDTH'(0)) begin
                  state_r     <= READ;
                  shift_en_r  <= 1'b0;
                  out_valid_r <= 1'b1;
                  out_last_r  <= (BUFLEN == 1);
                  rd_cnt_r    <= '0;
                end else begin
                  state_r <= POST;
                  post_r  <= post_cycles;
                end
              end
            end else begin
              fill_r <= fill_r + FILL_W'(1);
            end
          end
          POST: begin
            // Leaving at count 1 makes the last shift land on edge t+post_cycles.
            if (post_r == PWIDTH'(1)) begin
              state_r     <= READ;
              post_r      <= '0;
              shift_en_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_last_r  <= (BUFLEN == 1);
              rd_cnt_r    <= '0;
            end else begin
              post_r <= post_r - PWIDTH'(1);
            end
          end
          READ: begin
            if (out_ready) begin
              if (rd_cnt_r == RD_W'(BUFLEN - 1)) begin
                state_r     <= IDLE;
                rd_cnt_r    <= '0;
                shift_en_r  <= 1'b1;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                done_r      <= 1'b1;
              end else begin
                rd_cnt_r   <= rd_cnt_r + RD_W'(1);
                out_last_r <= (rd_cnt_r == RD_W'(BUFLEN - 2));
              end
            end
          end
          default: begin
            state_r    <= IDLE;
            shift_en_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign shift_en  = shift_en_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign done      = done_r;
  assign trig_lane = trig_lane_r;
  assign busy      = (state_r != IDLE);

endmodule
